// File: rtl/dram_cmd_sequencer.sv
// DRAM command timing stage: one command per cmd_req handshake, strobe then ack after T_x, plus refresh-interval timer.
// Optional row-state protocol checking is enabled by defining DRAM_SEQ_PROTOCOL_CHECK_EN.
module dram_cmd_sequencer #(
  parameter int T_RCD  = 3,
  parameter int T_CAS  = 2,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 8,
  parameter int T_REFI = 780,
  parameter int CNT_W  = 10
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       cmd_req,
  input  logic [1:0] cmd,
  output logic       cmd_ack,
  output logic       refresh_flag,
  output logic       refresh_miss,
  output logic       dram_act,
  output logic       dram_col,
  output logic       dram_ref,
  output logic       dram_pre,
  output logic       busy,
  output logic       protocol_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COUNT, S_RELEASE} state_t;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_COL = 2'b01;
  localparam logic [1:0] CMD_REF = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  localparam logic [CNT_W-1:0] LAT_ACT  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LAT_COL  = CNT_W'(T_CAS - 1);
  localparam logic [CNT_W-1:0] LAT_REF  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] LAT_PRE  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] REFI_RLD = CNT_W'(T_REFI - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       cmd_q, cmd_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] refi_q, refi_d;
  logic             ack_q, ack_d;
  logic             act_q, act_d, col_q, col_d, ref_q, ref_d, pre_q, pre_d;
  logic             busy_q, busy_d;
  logic             flag_q, flag_d, miss_q, miss_d;
  logic             expire, ref_ack;

  function automatic logic [CNT_W-1:0] lat_load(input logic [1:0] c);
    unique case (c)
      CMD_ACT: lat_load = LAT_ACT;
      CMD_COL: lat_load = LAT_COL;
      CMD_REF: lat_load = LAT_REF;
      default: lat_load = LAT_PRE;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    lat_d   = lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_req) begin
          state_d = S_ISSUE;
          cmd_d   = cmd;
        end
      end
      S_ISSUE: begin
        state_d = S_COUNT;
        lat_d   = lat_load(cmd_q);
      end
      S_COUNT: begin
        if (lat_q == '0) state_d = S_RELEASE;
        else             lat_d   = lat_q - CNT_ONE;
      end
      default: begin
        if (!cmd_req) state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values so each is visible in the cycle its state is.
  always_comb begin
    act_d   = (state_d == S_ISSUE) && (cmd_d == CMD_ACT);
    col_d   = (state_d == S_ISSUE) && (cmd_d == CMD_COL);
    ref_d   = (state_d == S_ISSUE) && (cmd_d == CMD_REF);
    pre_d   = (state_d == S_ISSUE) && (cmd_d == CMD_PRE);
    ack_d   = (state_d == S_COUNT) && (lat_d == '0);
    busy_d  = (state_d != S_IDLE);
    expire  = (refi_q == '0);
    refi_d  = expire ? REFI_RLD : refi_q - CNT_ONE;
    ref_ack = ack_d && (cmd_q == CMD_REF);
    // A refresh acked on the expiry edge served the pending request, so it is not a miss.
    flag_d  = expire | (flag_q & ~ref_ack);
    miss_d  = miss_q | (expire & flag_q & ~ref_ack);
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      cmd_q  <= CMD_ACT;
      lat_q  <= '0;
      refi_q <= REFI_RLD;
      ack_q  <= 1'b0;
      act_q  <= 1'b0;
      col_q  <= 1'b0;
      ref_q  <= 1'b0;
      pre_q  <= 1'b0;
      busy_q <= 1'b0;
      flag_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      lat_q  <= lat_d;
      refi_q <= refi_d;
      ack_q  <= ack_d;
      act_q  <= act_d;
      col_q  <= col_d;
      ref_q  <= ref_d;
      pre_q  <= pre_d;
      busy_q <= busy_d;
      flag_q <= flag_d;
      miss_q <= miss_d;
    end
  end

  assign cmd_ack      = ack_q;
  assign dram_act     = act_q;
  assign dram_col     = col_q;
  assign dram_ref     = ref_q;
  assign dram_pre     = pre_q;
  assign busy         = busy_q;
  assign refresh_flag = flag_q;
  assign refresh_miss = miss_q;

`ifdef DRAM_SEQ_PROTOCOL_CHECK_EN
  logic row_q, row_d, perr_q, perr_d;

  always_comb begin
    row_d  = row_q;
    perr_d = perr_q;
    if (state_q == S_IDLE && cmd_req) begin
      unique case (cmd)
        CMD_ACT: begin perr_d = perr_q | row_q;  row_d = 1'b1; end
        CMD_COL: begin perr_d = perr_q | ~row_q; end
        CMD_REF: begin perr_d = perr_q | row_q;  row_d = 1'b0; end
        default: begin row_d = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      row_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      perr_q <= perr_d;
    end
  end

  assign protocol_err = perr_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_dram_cmd_sequencer.sv
// Bench for dram_cmd_sequencer: event-time reference model compared every cycle plus directed literal checks.
module tb_dram_cmd_sequencer;
  localparam int T_RCD = 3, T_CAS = 2, T_RP = 3, T_RFC = 8, T_REFI = 20, CNT_W = 10;

  logic       clk = 1'b0;
  logic       rst_b = 1'b1;
  logic       cmd_req = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic cmd_ack, refresh_flag, refresh_miss, dram_act, dram_col, dram_ref, dram_pre, busy, protocol_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  dram_cmd_sequencer #(
    .T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cmd_req(cmd_req), .cmd(cmd),
    .cmd_ack(cmd_ack), .refresh_flag(refresh_flag), .refresh_miss(refresh_miss),
    .dram_act(dram_act), .dram_col(dram_col), .dram_ref(dram_ref), .dram_pre(dram_pre),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'b00:   return T_RCD;
      2'b01:   return T_CAS;
      2'b10:   return T_RFC;
      default: return T_RP;
    endcase
  endfunction

  // Reference model: a command accepted on edge t_acc strobes after that edge and acks after edge t_acc+T.
  bit m_busy, m_ack, m_flag, m_miss, m_err, m_row, expire, ref_ack;
  bit [3:0] m_strobe;
  logic [1:0] m_cmd;
  int t_acc, t_ack;

  always @(posedge clk) begin
    if (rst_b) begin
      cyc = 0; m_busy = 0; m_ack = 0; m_flag = 0; m_miss = 0; m_err = 0; m_row = 0;
      m_strobe = '0; t_acc = -10; t_ack = -10;
    end else begin
      cyc++;
      expire = (cyc % T_REFI) == 0;
      m_ack = 0;
      if (m_busy) begin
        if (cyc == t_ack) m_ack = 1;
        else if (cyc >= t_ack + 2 && !cmd_req) m_busy = 0;
      end else if (cmd_req) begin
        m_busy = 1; m_cmd = cmd; t_acc = cyc; t_ack = cyc + lat_of(cmd);
`ifdef DRAM_SEQ_PROTOCOL_CHECK_EN
        if ((cmd == 2'b00 && m_row) || (cmd == 2'b01 && !m_row) || (cmd == 2'b10 && m_row)) m_err = 1;
        if (cmd == 2'b00) m_row = 1;
        if (cmd == 2'b10 || cmd == 2'b11) m_row = 0;
`endif
      end
      m_strobe = (m_busy && cyc == t_acc) ? (4'b1000 >> m_cmd) : 4'b0000;
      ref_ack = m_ack && m_cmd == 2'b10;
      if (expire && m_flag && !ref_ack) m_miss = 1;
      if (expire) m_flag = 1;
      else if (ref_ack) m_flag = 0;
    end
    #1;
    chk("cmd_ack", int'(cmd_ack), int'(m_ack));
    chk("strobes", int'({dram_act, dram_col, dram_ref, dram_pre}), int'(m_strobe));
    chk("busy", int'(busy), int'(m_busy));
    chk("refresh_flag", int'(refresh_flag), int'(m_flag));
    chk("refresh_miss", int'(refresh_miss), int'(m_miss));
    chk("protocol_err", int'(protocol_err), int'(m_err));
  end

  // Issue one command; lat counts edges from the sampling edge through the ack edge inclusive.
  task automatic issue(input logic [1:0] c, input bit early, output int lat, output bit fa, output bit ma);
    lat = 0; fa = 0; ma = 0;
    @(negedge clk);
    cmd_req = 1'b1; cmd = c;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      lat++;
      if (i == 0) begin
        chk("strobe_one_hot", int'({dram_act, dram_col, dram_ref, dram_pre}), int'(4'b1000 >> c));
        cmd = ~c;
        if (early) cmd_req = 1'b0;
      end
      if (cmd_ack) break;
    end
    if (!cmd_ack) begin
      chk("ack_timeout", 0, 1);
      lat = -1;
    end
    fa = refresh_flag; ma = refresh_miss;
    if (early) begin
      @(posedge clk); #2;
      chk("early_release_busy", int'(busy), 1);
      @(posedge clk); #2;
      chk("early_idle_busy", int'(busy), 0);
    end
    @(negedge clk); cmd_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 200 && cyc < target; i++) begin
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int lat, n;
    bit fa, ma;
    repeat (3) @(negedge clk);
    rst_b = 1'b0;

    issue(2'b00, 0, lat, fa, ma); chk("lat_act", lat, 4);
    for (int k = 0; k < 8; k++) begin
      issue(2'b01, 0, lat, fa, ma); chk("lat_col", lat, 3);
    end
    issue(2'b11, 0, lat, fa, ma); chk("lat_pre", lat, 4);
    issue(2'b01, 1, lat, fa, ma); chk("lat_col_early_drop", lat, 3);

    // Reset in the middle of COUNT: outputs clear immediately, no ack afterwards.
    @(negedge clk); cmd_req = 1'b1; cmd = 2'b00;
    @(posedge clk); @(posedge clk); #3;
    rst_b = 1'b1; #1;
    chk("reset_outputs", int'({cmd_ack, refresh_flag, refresh_miss, dram_act, dram_col, dram_ref, dram_pre, busy, protocol_err}), 0);
    cmd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;

    n = 0;
    while (!refresh_flag && n < 40) begin
      @(posedge clk); #2; n++;
    end
    chk("refi_first_rise", n, 20);

    issue(2'b10, 0, lat, fa, ma);
    chk("lat_ref", lat, 9);
    chk("ref_ack_clears_flag", int'(fa), 0);
    wait_cyc(40);
    chk("flag_at_40", int'(refresh_flag), 1);
    chk("no_miss_at_40", int'(refresh_miss), 0);

    // Refresh sampled at edge 52 acks on edge 60, the next expiry.
    wait_cyc(51);
    issue(2'b10, 0, lat, fa, ma);
    chk("lat_ref_coincident", lat, 9);
    chk("coincident_flag", int'(fa), 1);
    chk("coincident_miss", int'(ma), 0);
    wait_cyc(80);
    chk("miss_at_80", int'(refresh_miss), 1);
    issue(2'b10, 0, lat, fa, ma);
    chk("flag_clear_after_miss", int'(fa), 0);
    chk("miss_sticky", int'(ma), 1);

    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    issue(2'b01, 0, lat, fa, ma);
    chk("lat_col_after_reset", lat, 3);
`ifdef DRAM_SEQ_PROTOCOL_CHECK_EN
    chk("protocol_err_col_no_row", int'(protocol_err), 1);
`else
    chk("protocol_err_tied_low", int'(protocol_err), 0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
